// File: rtl/axi_dmac_mc_regmap_pkg.sv
`default_nettype none
// ============================================================================
// axi_dmac_mc_regmap_pkg : register word addresses, flag bits, descriptor type
// Revision: 1.0
// ============================================================================
package axi_dmac_mc_regmap_pkg;

  localparam logic [13:0] c_reg_version     = 14'h000;
  localparam logic [13:0] c_reg_periph_id   = 14'h001;
  localparam logic [13:0] c_reg_scratch     = 14'h002;
  localparam logic [13:0] c_reg_ident       = 14'h003;
  localparam logic [13:0] c_reg_num_ch      = 14'h004;
  localparam logic [13:0] c_reg_irq_mask    = 14'h020;
  localparam logic [13:0] c_reg_irq_pending = 14'h021;
  localparam logic [13:0] c_reg_irq_source  = 14'h022;

  localparam logic [31:0] c_identification = 32'h444D4143;

  localparam logic [3:0] c_ch_control     = 4'h0;
  localparam logic [3:0] c_ch_transfer_id = 4'h1;
  localparam logic [3:0] c_ch_submit      = 4'h2;
  localparam logic [3:0] c_ch_flags       = 4'h3;
  localparam logic [3:0] c_ch_dest_addr   = 4'h4;
  localparam logic [3:0] c_ch_src_addr    = 4'h5;
  localparam logic [3:0] c_ch_x_length    = 4'h6;
  localparam logic [3:0] c_ch_y_length    = 4'h7;
  localparam logic [3:0] c_ch_dest_stride = 4'h8;
  localparam logic [3:0] c_ch_src_stride  = 4'h9;
  localparam logic [3:0] c_ch_done        = 4'hA;
  localparam logic [3:0] c_ch_active_id   = 4'hB;

  localparam int c_flag_cyclic     = 0;
  localparam int c_flag_last       = 1;
  localparam int c_flag_partial    = 2;
  localparam int c_flag_frame_lock = 3;

  localparam logic [3:0] c_flags_mask  = 4'((1 << c_flag_cyclic) | (1 << c_flag_last) |
                                            (1 << c_flag_partial) | (1 << c_flag_frame_lock));
  localparam logic [3:0] c_flags_reset = 4'(1 << c_flag_last);

  typedef struct packed {
    logic [3:0]  flags;
    logic [31:0] dest_addr;
    logic [31:0] src_addr;
    logic [31:0] x_length;
    logic [31:0] y_length;
    logic [31:0] dest_stride;
    logic [31:0] src_stride;
  } channel_regs_t;

  localparam channel_regs_t c_regs_reset = '{flags: c_flags_reset, dest_addr: 32'd0,
                                             src_addr: 32'd0, x_length: 32'd0, y_length: 32'd0,
                                             dest_stride: 32'd0, src_stride: 32'd0};

endpackage
`default_nettype wire

// File: rtl/axi_dmac_mc_channel.sv
`default_nettype none
// ============================================================================
// axi_dmac_mc_channel : one DMA channel - descriptor regs, ID queue, done map
// Revision: 1.0
// ============================================================================
module axi_dmac_mc_channel
  import axi_dmac_mc_regmap_pkg::*;
#(
  parameter int ID_WIDTH     = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int LENGTH_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en_i,
  input  logic [3:0]              wr_off_i,
  input  logic [31:0]             wdata_i,
  input  logic [3:0]              rd_off_i,
  output logic [31:0]             rdata_o,
  output logic                    enable_o,
  output logic                    pause_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [ADDR_WIDTH-1:0]   dest_addr_o,
  output logic [ADDR_WIDTH-1:0]   src_addr_o,
  output logic [LENGTH_WIDTH-1:0] x_length_o,
  output logic [LENGTH_WIDTH-1:0] y_length_o,
  output logic [LENGTH_WIDTH-1:0] dest_stride_o,
  output logic [LENGTH_WIDTH-1:0] src_stride_o,
  output logic [3:0]              flags_o,
  input  logic                    resp_eot_i,
  output logic                    queued_o,
  output logic                    completed_o
);

  localparam int c_depth = 1 << ID_WIDTH;
  localparam logic [ID_WIDTH:0] c_full = {1'b1, {ID_WIDTH{1'b0}}};
  localparam logic [31:0] c_addr_mask = (ADDR_WIDTH >= 32) ? '1 : 32'((64'd1 << ADDR_WIDTH) - 64'd1);
  localparam logic [31:0] c_len_mask  = (LENGTH_WIDTH >= 32) ? '1 : 32'((64'd1 << LENGTH_WIDTH) - 64'd1);

  channel_regs_t       regs_q, regs_d;
  logic                enable_q, enable_d, pause_q, pause_d, submit_q, submit_d;
  logic [ID_WIDTH-1:0] next_id_q, next_id_d, active_id_q, active_id_d;
  logic [ID_WIDTH:0]   outstanding_q, outstanding_d;
  logic [c_depth-1:0]  done_q, done_d;
  logic                accept, eot;

  // A full queue keeps the descriptor pending; submit stays set until space frees up.
  assign req_valid_o = enable_q && submit_q && (outstanding_q != c_full);
  assign accept      = req_valid_o && req_ready_i;
  assign eot         = enable_q && resp_eot_i && (outstanding_q != '0);
  assign queued_o    = accept;
  assign completed_o = eot;

  always_comb begin
    regs_d        = regs_q;
    enable_d      = enable_q;
    pause_d       = pause_q;
    submit_d      = submit_q;
    next_id_d     = next_id_q;
    active_id_d   = active_id_q;
    done_d        = done_q;
    outstanding_d = outstanding_q + (ID_WIDTH+1)'(accept) - (ID_WIDTH+1)'(eot);
    if (accept) begin
      submit_d          = 1'b0;
      done_d[next_id_q] = 1'b0;
      next_id_d         = next_id_q + 1'b1;
    end
    if (eot) begin
      done_d[active_id_q] = 1'b1;
      active_id_d         = active_id_q + 1'b1;
    end
    if (wr_en_i) begin
      case (wr_off_i)
        c_ch_control:     begin enable_d = wdata_i[0]; pause_d = wdata_i[1]; end
        c_ch_submit:      if (enable_q && wdata_i[0]) submit_d = 1'b1;
        c_ch_flags:       regs_d.flags       = wdata_i[3:0] & c_flags_mask;
        c_ch_dest_addr:   regs_d.dest_addr   = wdata_i & c_addr_mask;
        c_ch_src_addr:    regs_d.src_addr    = wdata_i & c_addr_mask;
        c_ch_x_length:    regs_d.x_length    = wdata_i & c_len_mask;
        c_ch_y_length:    regs_d.y_length    = wdata_i & c_len_mask;
        c_ch_dest_stride: regs_d.dest_stride = wdata_i & c_len_mask;
        c_ch_src_stride:  regs_d.src_stride  = wdata_i & c_len_mask;
        default: ;
      endcase
    end
    if (!enable_q) begin
      submit_d      = 1'b0;
      next_id_d     = '0;
      active_id_d   = '0;
      outstanding_d = '0;
      done_d        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q        <= c_regs_reset;
      enable_q      <= 1'b0;
      pause_q       <= 1'b0;
      submit_q      <= 1'b0;
      next_id_q     <= '0;
      active_id_q   <= '0;
      outstanding_q <= '0;
      done_q        <= '0;
    end else begin
      regs_q        <= regs_d;
      enable_q      <= enable_d;
      pause_q       <= pause_d;
      submit_q      <= submit_d;
      next_id_q     <= next_id_d;
      active_id_q   <= active_id_d;
      outstanding_q <= outstanding_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    case (rd_off_i)
      c_ch_control:     rdata_o = {30'd0, pause_q, enable_q};
      c_ch_transfer_id: rdata_o = 32'(next_id_q);
      c_ch_submit:      rdata_o = {31'd0, submit_q};
      c_ch_flags:       rdata_o = {28'd0, regs_q.flags};
      c_ch_dest_addr:   rdata_o = regs_q.dest_addr;
      c_ch_src_addr:    rdata_o = regs_q.src_addr;
      c_ch_x_length:    rdata_o = regs_q.x_length;
      c_ch_y_length:    rdata_o = regs_q.y_length;
      c_ch_dest_stride: rdata_o = regs_q.dest_stride;
      c_ch_src_stride:  rdata_o = regs_q.src_stride;
      c_ch_done:        rdata_o = 32'(done_q);
      c_ch_active_id:   rdata_o = 32'(active_id_q);
      default:          rdata_o = '0;
    endcase
  end

  assign enable_o      = enable_q;
  assign pause_o       = pause_q;
  assign flags_o       = regs_q.flags;
  assign dest_addr_o   = regs_q.dest_addr[ADDR_WIDTH-1:0];
  assign src_addr_o    = regs_q.src_addr[ADDR_WIDTH-1:0];
  assign x_length_o    = regs_q.x_length[LENGTH_WIDTH-1:0];
  assign y_length_o    = regs_q.y_length[LENGTH_WIDTH-1:0];
  assign dest_stride_o = regs_q.dest_stride[LENGTH_WIDTH-1:0];
  assign src_stride_o  = regs_q.src_stride[LENGTH_WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/axi_dmac_mc_regmap.sv
`default_nettype none
// ============================================================================
// axi_dmac_mc_regmap : multi-channel DMAC register map, decode and IRQ logic
// Revision: 1.0
// ============================================================================
module axi_dmac_mc_regmap
  import axi_dmac_mc_regmap_pkg::*;
#(
  parameter int          NUM_CHANNELS = 4,
  parameter int          ID_WIDTH     = 2,
  parameter int          ADDR_WIDTH   = 32,
  parameter int          LENGTH_WIDTH = 24,
  parameter logic [31:0] CORE_VERSION = 32'h00050061,
  parameter logic [31:0] ID           = 32'd0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 up_wreq,
  input  logic [13:0]                          up_waddr,
  input  logic [31:0]                          up_wdata,
  output logic                                 up_wack,
  input  logic                                 up_rreq,
  input  logic [13:0]                          up_raddr,
  output logic [31:0]                          up_rdata,
  output logic                                 up_rack,
  output logic                                 irq,
  output logic [NUM_CHANNELS-1:0]              ctrl_enable,
  output logic [NUM_CHANNELS-1:0]              ctrl_pause,
  output logic [NUM_CHANNELS-1:0]              req_valid,
  input  logic [NUM_CHANNELS-1:0]              req_ready,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   req_dest_address,
  output logic [NUM_CHANNELS*ADDR_WIDTH-1:0]   req_src_address,
  output logic [NUM_CHANNELS*LENGTH_WIDTH-1:0] req_x_length,
  output logic [NUM_CHANNELS*LENGTH_WIDTH-1:0] req_y_length,
  output logic [NUM_CHANNELS*LENGTH_WIDTH-1:0] req_dest_stride,
  output logic [NUM_CHANNELS*LENGTH_WIDTH-1:0] req_src_stride,
  output logic [NUM_CHANNELS*4-1:0]            req_flags,
  input  logic [NUM_CHANNELS-1:0]              resp_eot
);

  localparam int c_irq_w = 2 * NUM_CHANNELS;

  logic               up_wack_q, up_rack_q, irq_q;
  logic [31:0]        up_rdata_q, scratch_q, rdata_mux;
  logic [c_irq_w-1:0] irq_mask_q, irq_source_q, irq_source_d;
  logic [c_irq_w-1:0] irq_pending, irq_clear, irq_set;
  logic [31:0]        ch_rdata [NUM_CHANNELS];

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic ch_wr_en;
    assign ch_wr_en = up_wreq && (up_waddr[13:8] == 6'(c + 1)) && (up_waddr[7:4] == 4'd0);

    axi_dmac_mc_channel #(
      .ID_WIDTH     (ID_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .LENGTH_WIDTH (LENGTH_WIDTH)
    ) u_channel (
      .clk           (clk),
      .reset         (reset),
      .wr_en_i       (ch_wr_en),
      .wr_off_i      (up_waddr[3:0]),
      .wdata_i       (up_wdata),
      .rd_off_i      (up_raddr[3:0]),
      .rdata_o       (ch_rdata[c]),
      .enable_o      (ctrl_enable[c]),
      .pause_o       (ctrl_pause[c]),
      .req_valid_o   (req_valid[c]),
      .req_ready_i   (req_ready[c]),
      .dest_addr_o   (req_dest_address[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .src_addr_o    (req_src_address[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .x_length_o    (req_x_length[c*LENGTH_WIDTH +: LENGTH_WIDTH]),
      .y_length_o    (req_y_length[c*LENGTH_WIDTH +: LENGTH_WIDTH]),
      .dest_stride_o (req_dest_stride[c*LENGTH_WIDTH +: LENGTH_WIDTH]),
      .src_stride_o  (req_src_stride[c*LENGTH_WIDTH +: LENGTH_WIDTH]),
      .flags_o       (req_flags[c*4 +: 4]),
      .resp_eot_i    (resp_eot[c]),
      .queued_o      (irq_set[2*c]),
      .completed_o   (irq_set[2*c+1])
    );
  end

  // Writing either PENDING or SOURCE clears source bits; a same-cycle hardware set wins.
  assign irq_pending  = irq_source_q & ~irq_mask_q;
  assign irq_clear    = (up_wreq && (up_waddr == c_reg_irq_pending || up_waddr == c_reg_irq_source))
                        ? up_wdata[c_irq_w-1:0] : '0;
  assign irq_source_d = (irq_source_q & ~irq_clear) | irq_set;

  always_comb begin
    rdata_mux = '0;
    if (up_raddr[13:8] == 6'd0) begin
      case (up_raddr)
        c_reg_version:     rdata_mux = CORE_VERSION;
        c_reg_periph_id:   rdata_mux = ID;
        c_reg_scratch:     rdata_mux = scratch_q;
        c_reg_ident:       rdata_mux = c_identification;
        c_reg_num_ch:      rdata_mux = 32'(NUM_CHANNELS);
        c_reg_irq_mask:    rdata_mux = 32'(irq_mask_q);
        c_reg_irq_pending: rdata_mux = 32'(irq_pending);
        c_reg_irq_source:  rdata_mux = 32'(irq_source_q);
        default:           rdata_mux = '0;
      endcase
    end else if (up_raddr[7:4] == 4'd0) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (up_raddr[13:8] == 6'(c + 1)) rdata_mux = ch_rdata[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      up_wack_q    <= 1'b0;
      up_rack_q    <= 1'b0;
      up_rdata_q   <= '0;
      scratch_q    <= '0;
      irq_mask_q   <= '1;
      irq_source_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      up_wack_q    <= up_wreq;
      up_rack_q    <= up_rreq;
      up_rdata_q   <= up_rreq ? rdata_mux : '0;
      irq_source_q <= irq_source_d;
      irq_q        <= |irq_pending;
      if (up_wreq && up_waddr == c_reg_scratch)  scratch_q  <= up_wdata;
      if (up_wreq && up_waddr == c_reg_irq_mask) irq_mask_q <= up_wdata[c_irq_w-1:0];
    end
  end

  assign up_wack  = up_wack_q;
  assign up_rack  = up_rack_q;
  assign up_rdata = up_rdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_dmac_mc_regmap.sv
`default_nettype none
// ============================================================================
// tb_axi_dmac_mc_regmap : scoreboard bench for the multi-channel DMAC regmap
// Revision: 1.0
// ============================================================================
module tb_axi_dmac_mc_regmap;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int LW = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic            up_wreq, up_rreq;
  logic [13:0]     up_waddr, up_raddr;
  logic [31:0]     up_wdata, up_rdata;
  logic            up_wack, up_rack, irq;
  logic [N-1:0]    ctrl_enable, ctrl_pause, req_valid, req_ready, resp_eot;
  logic [N*AW-1:0] req_dest_address, req_src_address;
  logic [N*LW-1:0] req_x_length, req_y_length, req_dest_stride, req_src_stride;
  logic [N*4-1:0]  req_flags;

  axi_dmac_mc_regmap dut (
    .clk(clk), .reset(reset),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .irq(irq), .ctrl_enable(ctrl_enable), .ctrl_pause(ctrl_pause),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dest_address(req_dest_address), .req_src_address(req_src_address),
    .req_x_length(req_x_length), .req_y_length(req_y_length),
    .req_dest_stride(req_dest_stride), .req_src_stride(req_src_stride),
    .req_flags(req_flags), .resp_eot(resp_eot)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_exp_q [$];
  logic [13:0] rd_addr_q [$];
  int          rd_cyc_q [$];
  int          acc_ch_q [$];
  logic [31:0] acc_dest_q [$];
  logic [31:0] acc_xlen_q [$];
  logic [3:0]  acc_flags_q [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  // Monitor: samples on the falling edge and retires scoreboard entries.
  logic        wreq_prev = 1'b0;
  logic [31:0] m_exp, m_dest, m_xlen;
  logic [13:0] m_addr;
  logic [3:0]  m_flags;
  int          m_cyc, m_ch;
  always @(negedge clk) begin
    if (up_wack || wreq_prev) chk("wack_latency", 32'(up_wack), 32'(wreq_prev));
    wreq_prev = up_wreq;
    if (up_rack) begin
      if (rd_exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rack_unexpected: got rack 1 required 0");
      end else begin
        m_exp  = rd_exp_q.pop_front();
        m_addr = rd_addr_q.pop_front();
        m_cyc  = rd_cyc_q.pop_front();
        chk($sformatf("rd_%03h", m_addr), up_rdata, m_exp);
        chk($sformatf("rack_cycle_%03h", m_addr), 32'(cyc), 32'(m_cyc));
      end
    end
    for (int c = 0; c < N; c++) begin
      if (req_valid[c] && req_ready[c]) begin
        if (acc_ch_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL accept_unexpected: ch%0d got accept required none", c);
        end else begin
          m_ch    = acc_ch_q.pop_front();
          m_dest  = acc_dest_q.pop_front();
          m_xlen  = acc_xlen_q.pop_front();
          m_flags = acc_flags_q.pop_front();
          chk("acc_channel", 32'(c), 32'(m_ch));
          chk("acc_dest", req_dest_address[c*AW +: AW], m_dest);
          chk("acc_xlen", 32'(req_x_length[c*LW +: LW]), m_xlen);
          chk("acc_flags", 32'(req_flags[c*4 +: 4]), 32'(m_flags));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    tick();
    up_wreq = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] exp);
    rd_exp_q.push_back(exp);
    rd_addr_q.push_back(a);
    rd_cyc_q.push_back(cyc + 1);
    up_rreq = 1'b1; up_raddr = a;
    tick();
    up_rreq = 1'b0;
  endtask

  task automatic expect_acc(input int ch, input logic [31:0] dest, input logic [31:0] xlen,
                            input logic [3:0] flags);
    acc_ch_q.push_back(ch);
    acc_dest_q.push_back(dest);
    acc_xlen_q.push_back(xlen);
    acc_flags_q.push_back(flags);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; up_wreq = 1'b0; up_rreq = 1'b0; up_waddr = '0; up_raddr = '0;
    up_wdata = '0; req_ready = '1; resp_eot = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_outputs", {20'd0, up_wack, up_rack, irq, req_valid, ctrl_enable, ctrl_pause}, 32'd0);
    chk("reset_rdata", up_rdata, 32'd0);

    // Global map and reset values
    rd(14'h003, 32'h444D4143);
    rd(14'h020, 32'h000000FF);
    rd(14'h103, 32'h00000002);
    rd(14'h000, 32'h00050061);
    rd(14'h001, 32'h00000000);
    rd(14'h004, 32'h00000004);
    rd(14'h050, 32'h00000000);
    rd(14'h10C, 32'h00000000);
    wr(14'h002, 32'hDEADBEEF);
    wr(14'h030, 32'h12345678);
    rd(14'h002, 32'hDEADBEEF);

    // Channel 1: submit while disabled is ignored, then one descriptor
    wr(14'h202, 32'h1);
    rd(14'h202, 32'h0);
    wr(14'h200, 32'h1);
    chk("ch1_enable", 32'(ctrl_enable), 32'h2);
    wr(14'h206, 32'h3FF);
    wr(14'h204, 32'h80000000);
    expect_acc(1, 32'h80000000, 32'h3FF, 4'h2);
    wr(14'h202, 32'h1);
    tick();
    rd(14'h201, 32'h1);
    rd(14'h202, 32'h0);
    rd(14'h022, 32'h4);
    wr(14'h022, 32'hFF);

    // Channel 0: fill the 4-deep queue, fifth descriptor waits for an eot
    wr(14'h100, 32'h1);
    wr(14'h104, 32'h1000);
    wr(14'h106, 32'h10);
    wr(14'h103, 32'hFF);
    for (int i = 0; i < 4; i++) begin
      expect_acc(0, 32'h1000, 32'h10, 4'hF);
      wr(14'h102, 32'h1);
      tick();
    end
    rd(14'h101, 32'h0);
    wr(14'h102, 32'h1);
    tick();
    chk("ch0_full_valid", 32'(req_valid[0]), 32'd0);
    rd(14'h102, 32'h1);
    expect_acc(0, 32'h1000, 32'h10, 4'hF);
    resp_eot[0] = 1'b1;
    tick();
    resp_eot[0] = 1'b0;
    rd(14'h10A, 32'h1);
    rd(14'h10A, 32'h0);
    rd(14'h10B, 32'h1);
    rd(14'h101, 32'h1);

    // IRQ: set beats RW1C clear, then masking controls irq with one cycle lag
    resp_eot[0] = 1'b1;
    wr(14'h022, 32'h2);
    resp_eot[0] = 1'b0;
    rd(14'h022, 32'h3);
    wr(14'h022, 32'h1);
    rd(14'h022, 32'h2);
    rd(14'h021, 32'h0);
    wr(14'h020, 32'h0);
    chk("irq_lag", 32'(irq), 32'd0);
    tick();
    chk("irq_rise", 32'(irq), 32'd1);
    rd(14'h021, 32'h2);
    wr(14'h021, 32'h2);
    chk("irq_hold", 32'(irq), 32'd1);
    tick();
    chk("irq_fall", 32'(irq), 32'd0);

    // Channel 2: disable with two outstanding, re-enable from ID 0
    wr(14'h300, 32'h1);
    for (int i = 0; i < 3; i++) begin
      expect_acc(2, 32'h0, 32'h0, 4'h2);
      wr(14'h302, 32'h1);
      tick();
    end
    rd(14'h301, 32'h3);
    resp_eot[2] = 1'b1;
    tick();
    resp_eot[2] = 1'b0;
    rd(14'h30A, 32'h1);
    wr(14'h300, 32'h0);
    tick();
    wr(14'h302, 32'h1);
    rd(14'h302, 32'h0);
    wr(14'h300, 32'h1);
    rd(14'h301, 32'h0);
    rd(14'h30B, 32'h0);
    rd(14'h30A, 32'h0);
    wr(14'h022, 32'hFF);
    for (int i = 0; i < 2; i++) begin
      resp_eot[2] = 1'b1;
      tick();
      resp_eot[2] = 1'b0;
      tick();
    end
    rd(14'h30A, 32'h0);
    rd(14'h30B, 32'h0);
    rd(14'h022, 32'h0);

    // Channel 3: reset while a descriptor is pending
    wr(14'h400, 32'h1);
    expect_acc(3, 32'h0, 32'h0, 4'h2);
    wr(14'h402, 32'h1);
    tick();
    req_ready[3] = 1'b0;
    wr(14'h402, 32'h1);
    tick();
    chk("ch3_pending_valid", 32'(req_valid[3]), 32'd1);
    chk("irq_before_reset", 32'(irq), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("reset_mid_valid", 32'(req_valid), 32'd0);
    chk("reset_mid_irq", 32'(irq), 32'd0);
    chk("reset_mid_enable", 32'(ctrl_enable), 32'd0);
    req_ready = '1;
    rd(14'h401, 32'h0);
    rd(14'h402, 32'h0);
    rd(14'h101, 32'h0);
    rd(14'h020, 32'hFF);
    rd(14'h022, 32'h0);
    repeat (3) tick();

    while (rd_exp_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL rack_missing: addr %03h got no rack required rack", rd_addr_q.pop_front());
      void'(rd_exp_q.pop_front());
      void'(rd_cyc_q.pop_front());
    end
    while (acc_ch_q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL accept_missing: ch%0d got no accept required accept", acc_ch_q.pop_front());
      void'(acc_dest_q.pop_front());
      void'(acc_xlen_q.pop_front());
      void'(acc_flags_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
